// File: rtl/ctrlbus_bridge_pipe_if.sv
// rtl/ctrlbus_bridge_pipe_if.sv - ctrl-bus bundle, N lanes wide (N=1 upstream, N=M_COUNT downstream).
interface ctrlbus_bridge_pipe_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int N          = 1
);
    logic [N-1:0]            wen;
    logic [N*ADDR_WIDTH-1:0] waddr;
    logic [N*DATA_WIDTH-1:0] wdata;
    logic [N-1:0]            ren;
    logic [N*ADDR_WIDTH-1:0] raddr;
    logic [N*DATA_WIDTH-1:0] rdata;
    logic                    rvalid;

    modport master (
        output wen, waddr, wdata, ren, raddr,
        input  rdata, rvalid
    );

    modport slave (
        input  wen, waddr, wdata, ren, raddr,
        output rdata, rvalid
    );
endinterface

// File: rtl/ctrlbus_bridge_pipe.sv
// rtl/ctrlbus_bridge_pipe.sv - pipelined 1-to-M_COUNT ctrl-bus demux; miss log built when CTRLBUS_BRIDGE_MISS_LOG_EN is defined.
module ctrlbus_bridge_pipe #(
    parameter int                            ADDR_WIDTH  = 32,
    parameter int                            DATA_WIDTH  = 32,
    parameter int                            M_COUNT     = 2,
    parameter logic [M_COUNT*ADDR_WIDTH-1:0] M_BASE_LIST = '0,
    parameter logic [M_COUNT*ADDR_WIDTH-1:0] M_MASK_LIST = '0,
    parameter logic [DATA_WIDTH-1:0]         MISS_DATA   = 32'hDEADBEEF,
    parameter int                            CNT_WIDTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    ctrlbus_bridge_pipe_if.slave        s_ctrl,
    ctrlbus_bridge_pipe_if.master       m_ctrl,
    input  logic                        miss_clr,
    output logic [CNT_WIDTH-1:0]        miss_count,
    output logic [ADDR_WIDTH-1:0]       miss_addr
);

    // Descending scan so the lowest matching index is the one left standing.
    function automatic logic [M_COUNT-1:0] decode(input logic [ADDR_WIDTH-1:0] a);
        logic [M_COUNT-1:0] s;
        s = '0;
        for (int i = M_COUNT - 1; i >= 0; i--) begin
            if ((a & M_MASK_LIST[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                (M_BASE_LIST[i*ADDR_WIDTH +: ADDR_WIDTH] & M_MASK_LIST[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                s    = '0;
                s[i] = 1'b1;
            end
        end
        return s;
    endfunction

    logic [M_COUNT-1:0]    w_sel, r_sel;
    logic [M_COUNT-1:0]    wen_q, ren_q;
    logic [ADDR_WIDTH-1:0] waddr_q, raddr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q, slave_rdata;
    logic                  rpend_q, rvalid_q;

    assign w_sel = decode(s_ctrl.waddr[ADDR_WIDTH-1:0]);
    assign r_sel = decode(s_ctrl.raddr[ADDR_WIDTH-1:0]);

    // ren_q is already the one-hot registered select, so it steers the return mux.
    always_comb begin
        slave_rdata = '0;
        for (int i = 0; i < M_COUNT; i++) begin
            if (ren_q[i]) slave_rdata = slave_rdata | m_ctrl.rdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_q    <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            ren_q    <= '0;
            raddr_q  <= '0;
            rpend_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            wen_q <= s_ctrl.wen[0] ? w_sel : '0;
            if (s_ctrl.wen[0]) begin
                waddr_q <= s_ctrl.waddr[ADDR_WIDTH-1:0];
                wdata_q <= s_ctrl.wdata[DATA_WIDTH-1:0];
            end
            ren_q   <= s_ctrl.ren[0] ? r_sel : '0;
            if (s_ctrl.ren[0]) raddr_q <= s_ctrl.raddr[ADDR_WIDTH-1:0];
            rpend_q  <= s_ctrl.ren[0];
            rvalid_q <= rpend_q;
            if (rpend_q) rdata_q <= (|ren_q) ? slave_rdata : MISS_DATA;
        end
    end

    assign m_ctrl.wen   = wen_q;
    assign m_ctrl.waddr = {M_COUNT{waddr_q}};
    assign m_ctrl.wdata = {M_COUNT{wdata_q}};
    assign m_ctrl.ren   = ren_q;
    assign m_ctrl.raddr = {M_COUNT{raddr_q}};
    assign s_ctrl.rdata  = rdata_q;
    assign s_ctrl.rvalid = rvalid_q;

`ifdef CTRLBUS_BRIDGE_MISS_LOG_EN
    logic                  r_miss, w_miss;
    logic [CNT_WIDTH+1:0]  miss_sum;
    logic [CNT_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;
    logic [ADDR_WIDTH-1:0] miss_addr_q, miss_addr_d;

    assign r_miss = s_ctrl.ren[0] & ~(|r_sel);
    assign w_miss = s_ctrl.wen[0] & ~(|w_sel);

    // Two extra sum bits let a +2 near the top be detected instead of wrapping.
    always_comb begin
        miss_sum    = {2'b00, miss_cnt_q} + (CNT_WIDTH+2)'(r_miss) + (CNT_WIDTH+2)'(w_miss);
        miss_cnt_d  = (miss_sum > {2'b00, {CNT_WIDTH{1'b1}}}) ? {CNT_WIDTH{1'b1}} : miss_sum[CNT_WIDTH-1:0];
        miss_addr_d = miss_addr_q;
        if (w_miss) miss_addr_d = s_ctrl.waddr[ADDR_WIDTH-1:0];
        if (r_miss) miss_addr_d = s_ctrl.raddr[ADDR_WIDTH-1:0];
        if (miss_clr) begin
            miss_cnt_d  = '0;
            miss_addr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_cnt_q  <= '0;
            miss_addr_q <= '0;
        end else begin
            miss_cnt_q  <= miss_cnt_d;
            miss_addr_q <= miss_addr_d;
        end
    end

    assign miss_count = miss_cnt_q;
    assign miss_addr  = miss_addr_q;
`else
    logic miss_clr_unused;
    assign miss_clr_unused = miss_clr;
    assign miss_count      = '0;
    assign miss_addr       = '0;
`endif

endmodule
